// File: rtl/dcache_controller.sv
// Write-back, write-allocate data-cache controller: sequences hits, dirty-line
// writeback, line allocation and CLFLUSH between pipeline, datapath and L2.
package dcache_controller_pkg;
    typedef enum logic [1:0] {
        MO_LOAD    = 2'd0,
        MO_STORE   = 2'd1,
        MO_CLFLUSH = 2'd2,
        MO_UNKNOWN = 2'd3
    } memory_operation_e;
endpackage

module dcache_controller
    import dcache_controller_pkg::*;
#(
    parameter int  WORDS_PER_BLOCK = 8,
    localparam int CW              = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_req_valid,
    input  memory_operation_e pipe_req_type,
    output logic              pipe_req_fulfilled,
    input  logic              l2_req_fulfilled,
    output memory_operation_e l2_req_type,
    output logic              l2_req_valid,
    input  logic              valid_block_match,
    input  logic              victim_dirty,
    output logic              load_mode,
    output logic              writeback_mode,
    output logic              perform_write,
    output logic              set_dirty_bit,
    output logic              clear_selected_valid_bit,
    output logic              clear_selected_dirty_bit,
    output logic              set_writeback_l2_block_address,
    output logic              set_new_l2_block_address,
    output logic              finish_new_line_install,
    output logic [CW-1:0]     word_index
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_BLOCK - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          flush_q, flush_d;

    logic last_word_done_s;
    assign last_word_done_s = l2_req_fulfilled && (count_q == LAST_WORD);
    assign word_index       = count_q;

    // State, block word counter and flush flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= {CW{1'b0}};
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            flush_q <= flush_d;
        end
    end

    // Next-state, counter and flush-flag logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        flush_d = flush_q;
        case (state_q)
            ST_IDLE: begin
                if (pipe_req_valid) begin
                    case (pipe_req_type)
                        MO_LOAD, MO_STORE: begin
                            if (!valid_block_match) begin
                                count_d = {CW{1'b0}};
                                if (victim_dirty) begin
                                    state_d = ST_WRITEBACK;
                                    flush_d = 1'b0;
                                end else begin
                                    state_d = ST_ALLOCATE;
                                end
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        MO_CLFLUSH: begin
                            if (valid_block_match && victim_dirty) begin
                                state_d = ST_WRITEBACK;
                                count_d = {CW{1'b0}};
                                flush_d = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                if (l2_req_fulfilled) begin
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_WORD) begin
                        state_d = flush_q ? ST_IDLE : ST_ALLOCATE;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                if (l2_req_fulfilled) begin
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_WORD) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ALLOCATE;
                    end
                end else begin
                    state_d = ST_ALLOCATE;
                end
            end
            default: begin
                state_d = state_e'(2'bxx);
                count_d = {CW{1'bx}};
                flush_d = 1'bx;
            end
        endcase
    end

    // Output decode; reset forces everything idle so an aborted burst emits nothing.
    always_comb begin
        pipe_req_fulfilled             = 1'b0;
        l2_req_type                    = MO_LOAD;
        l2_req_valid                   = 1'b0;
        load_mode                      = 1'b0;
        writeback_mode                 = 1'b0;
        perform_write                  = 1'b0;
        set_dirty_bit                  = 1'b0;
        clear_selected_valid_bit       = 1'b0;
        clear_selected_dirty_bit       = 1'b0;
        set_writeback_l2_block_address = 1'b0;
        set_new_l2_block_address       = 1'b0;
        finish_new_line_install        = 1'b0;
        if (!reset) begin
            l2_req_type = MO_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pipe_req_valid) begin
                        case (pipe_req_type)
                            MO_LOAD, MO_STORE: begin
                                if (valid_block_match) begin
                                    pipe_req_fulfilled = 1'b1;
                                    perform_write      = (pipe_req_type == MO_STORE);
                                    set_dirty_bit      = (pipe_req_type == MO_STORE);
                                end else if (victim_dirty) begin
                                    set_writeback_l2_block_address = 1'b1;
                                end else begin
                                    set_new_l2_block_address = 1'b1;
                                end
                            end
                            MO_CLFLUSH: begin
                                if (!valid_block_match) begin
                                    pipe_req_fulfilled = 1'b1;
                                end else if (!victim_dirty) begin
                                    clear_selected_valid_bit = 1'b1;
                                    pipe_req_fulfilled       = 1'b1;
                                end else begin
                                    set_writeback_l2_block_address = 1'b1;
                                end
                            end
                            default: pipe_req_fulfilled = 1'b0;
                        endcase
                    end else begin
                        pipe_req_fulfilled = 1'b0;
                    end
                end
                ST_WRITEBACK: begin
                    l2_req_valid   = 1'b1;
                    l2_req_type    = MO_STORE;
                    writeback_mode = 1'b1;
                    if (last_word_done_s && flush_q) begin
                        clear_selected_valid_bit = 1'b1;
                        clear_selected_dirty_bit = 1'b1;
                        pipe_req_fulfilled       = 1'b1;
                    end else if (last_word_done_s) begin
                        set_new_l2_block_address = 1'b1;
                    end else begin
                        pipe_req_fulfilled = 1'b0;
                    end
                end
                ST_ALLOCATE: begin
                    l2_req_valid  = 1'b1;
                    l2_req_type   = MO_LOAD;
                    load_mode     = 1'b1;
                    perform_write = l2_req_fulfilled;
                    if (last_word_done_s) begin
                        finish_new_line_install  = 1'b1;
                        clear_selected_dirty_bit = 1'b1;
                    end else begin
                        finish_new_line_install = 1'b0;
                    end
                end
                default: begin
                    pipe_req_fulfilled             = 1'bx;
                    l2_req_type                    = MO_UNKNOWN;
                    l2_req_valid                   = 1'bx;
                    load_mode                      = 1'bx;
                    writeback_mode                 = 1'bx;
                    perform_write                  = 1'bx;
                    set_dirty_bit                  = 1'bx;
                    clear_selected_valid_bit       = 1'bx;
                    clear_selected_dirty_bit       = 1'bx;
                    set_writeback_l2_block_address = 1'bx;
                    set_new_l2_block_address       = 1'bx;
                    finish_new_line_install        = 1'bx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a one-line cache model turns each pipeline
// request into the expected per-cycle output trace, compared every cycle.
module tb_dcache_controller;
    import dcache_controller_pkg::*;

    localparam int WPB = 8;
    localparam int CW  = $clog2(WPB);

    typedef struct packed {
        logic          pf;
        logic          l2v;
        logic [1:0]    l2t;
        logic          lm;
        logic          wbm;
        logic          pw;
        logic          sd;
        logic          csv;
        logic          csd;
        logic          swa;
        logic          sna;
        logic          fin;
        logic [CW-1:0] wi;
    } outs_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              pipe_req_valid;
    memory_operation_e pipe_req_type;
    logic              pipe_req_fulfilled;
    logic              l2_req_fulfilled;
    memory_operation_e l2_req_type;
    logic              l2_req_valid;
    logic              valid_block_match;
    logic              victim_dirty;
    logic              load_mode, writeback_mode, perform_write, set_dirty_bit;
    logic              clear_selected_valid_bit, clear_selected_dirty_bit;
    logic              set_writeback_l2_block_address, set_new_l2_block_address;
    logic              finish_new_line_install;
    logic [CW-1:0]     word_index;

    dcache_controller #(.WORDS_PER_BLOCK(WPB)) dut (
        .clk                            (clk),
        .reset                          (reset),
        .pipe_req_valid                 (pipe_req_valid),
        .pipe_req_type                  (pipe_req_type),
        .pipe_req_fulfilled             (pipe_req_fulfilled),
        .l2_req_fulfilled               (l2_req_fulfilled),
        .l2_req_type                    (l2_req_type),
        .l2_req_valid                   (l2_req_valid),
        .valid_block_match              (valid_block_match),
        .victim_dirty                   (victim_dirty),
        .load_mode                      (load_mode),
        .writeback_mode                 (writeback_mode),
        .perform_write                  (perform_write),
        .set_dirty_bit                  (set_dirty_bit),
        .clear_selected_valid_bit       (clear_selected_valid_bit),
        .clear_selected_dirty_bit       (clear_selected_dirty_bit),
        .set_writeback_l2_block_address (set_writeback_l2_block_address),
        .set_new_l2_block_address       (set_new_l2_block_address),
        .finish_new_line_install        (finish_new_line_install),
        .word_index                     (word_index)
    );

    always #5 clk = ~clk;

    outs_t dut_o;
    assign dut_o = {pipe_req_fulfilled, l2_req_valid, l2_req_type, load_mode, writeback_mode,
                    perform_write, set_dirty_bit, clear_selected_valid_bit,
                    clear_selected_dirty_bit, set_writeback_l2_block_address,
                    set_new_l2_block_address, finish_new_line_install, word_index};

    // Cache model: the single line selected by the request index.
    bit       line_valid, line_dirty;
    int       line_tag, req_tag;

    outs_t    exp;
    bit       check_en = 1'b0;
    string    cur_name = "reset";
    int       step_cnt = 0;
    int       lit_seq = 0, lit_done = 0, lit_act, lit_exp;
    string    lit_name;

    int       n_tests = 0, n_fail = 0;
    int       pw_cnt = 0, fin_cnt = 0, pf_cnt = 0;

    // Single compare process: cycle trace check plus pending literal checks.
    always @(negedge clk) begin
        if (check_en) begin
            n_tests++;
            if (dut_o !== exp) begin
                n_fail++;
                $display("FAIL %s step %0d: outputs got %h expected %h", cur_name, step_cnt, dut_o, exp);
            end
            pw_cnt  += int'(perform_write === 1'b1);
            fin_cnt += int'(finish_new_line_install === 1'b1);
            pf_cnt  += int'(pipe_req_fulfilled === 1'b1);
        end
        if (lit_seq != lit_done) begin
            n_tests++;
            if (lit_act != lit_exp) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", lit_name, lit_act, lit_exp);
            end
            lit_done = lit_seq;
        end
    end

    function automatic outs_t base();
        outs_t o;
        o     = '0;
        o.l2t = MO_LOAD;
        return o;
    endfunction

    function automatic outs_t burst_e(input bit is_wb, input int w);
        outs_t o;
        o     = base();
        o.l2v = 1'b1;
        o.l2t = is_wb ? MO_STORE : MO_LOAD;
        o.wbm = is_wb;
        o.lm  = !is_wb;
        o.wi  = CW'(w);
        return o;
    endfunction

    task automatic step(input logic l2f, input outs_t e);
        l2_req_fulfilled  = l2f;
        valid_block_match = line_valid && (line_tag == req_tag);
        victim_dirty      = line_valid && line_dirty;
        exp               = e;
        check_en          = 1'b1;
        step_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string nm, input int act, input int expv);
        check_en = 1'b0;
        lit_name = nm;
        lit_act  = act;
        lit_exp  = expv;
        lit_seq++;
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    // One L2 burst of WPB words; L2 answers after 'gap' idle cycles per word.
    task automatic burst(input bit is_wb, input bit flush, input int gap);
        outs_t e;
        for (int w = 0; w < WPB; w++) begin
            e = burst_e(is_wb, w);
            repeat (gap) step(1'b0, e);
            if (!is_wb) e.pw = 1'b1;
            if (w == WPB - 1) begin
                if (!is_wb) begin
                    e.fin = 1'b1;
                    e.csd = 1'b1;
                end else if (flush) begin
                    e.csv = 1'b1;
                    e.csd = 1'b1;
                    e.pf  = 1'b1;
                end else begin
                    e.sna = 1'b1;
                end
            end
            step(1'b1, e);
        end
    endtask

    task automatic request(input memory_operation_e op, input int gap);
        bit    hit, dirty;
        outs_t e;
        hit            = line_valid && (line_tag == req_tag);
        dirty          = line_valid && line_dirty;
        pipe_req_valid = 1'b1;
        pipe_req_type  = op;
        e              = base();
        if (op == MO_CLFLUSH) begin
            if (!hit) begin
                e.pf = 1'b1;
                step(1'b0, e);
            end else if (!dirty) begin
                e.pf  = 1'b1;
                e.csv = 1'b1;
                step(1'b0, e);
                line_valid = 1'b0;
            end else begin
                e.swa = 1'b1;
                step(1'b0, e);
                burst(1'b1, 1'b1, gap);
                line_valid = 1'b0;
                line_dirty = 1'b0;
            end
        end else begin
            if (!hit) begin
                e.swa = dirty;
                e.sna = !dirty;
                step(1'b0, e);
                if (dirty) burst(1'b1, 1'b0, gap);
                burst(1'b0, 1'b0, gap);
                line_valid = 1'b1;
                line_tag   = req_tag;
                line_dirty = 1'b0;
                e          = base();
            end
            e.pf = 1'b1;
            if (op == MO_STORE) begin
                e.pw = 1'b1;
                e.sd = 1'b1;
            end
            step(1'b0, e);
            if (op == MO_STORE) line_dirty = 1'b1;
        end
        pipe_req_valid = 1'b0;
    endtask

    int s0, pw0, fin0, pf0;

    initial begin
        line_valid = 1'b1; line_dirty = 1'b0; line_tag = 5; req_tag = 5;
        reset             = 1'b0;
        pipe_req_valid    = 1'b1;
        pipe_req_type     = MO_LOAD;
        l2_req_fulfilled  = 1'b1;
        valid_block_match = 1'b1;
        victim_dirty      = 1'b0;
        exp               = base();
        check_en          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pipe_req_valid = 1'b0;
        reset          = 1'b1;

        cur_name = "load_hit_b2b";
        s0 = step_cnt; pf0 = pf_cnt; pw0 = pw_cnt;
        request(MO_LOAD, 0);
        request(MO_LOAD, 0);
        check_lit("b2b_hit_cycles", step_cnt - s0, 2);
        check_lit("b2b_hit_fulfilled", pf_cnt - pf0, 2);
        check_lit("load_hit_no_write", pw_cnt - pw0, 0);

        cur_name = "store_hit";
        request(MO_STORE, 0);

        cur_name = "idle_ignores_l2";
        step(1'b1, base());
        step(1'b0, base());

        cur_name = "clflush_miss";
        req_tag = 9;
        request(MO_CLFLUSH, 0);

        cur_name = "clflush_dirty";
        req_tag = 5;
        s0 = step_cnt; pf0 = pf_cnt; pw0 = pw_cnt; fin0 = fin_cnt;
        request(MO_CLFLUSH, 1);
        check_lit("flush_cycles", step_cnt - s0, 17);
        check_lit("flush_fulfilled", pf_cnt - pf0, 1);
        check_lit("flush_no_alloc", fin_cnt - fin0 + pw_cnt - pw0, 0);

        cur_name = "load_miss_clean";
        s0 = step_cnt; pw0 = pw_cnt; fin0 = fin_cnt;
        request(MO_LOAD, 1);
        check_lit("ldmiss_cycles", step_cnt - s0, 18);
        check_lit("ldmiss_writes", pw_cnt - pw0, 8);
        check_lit("ldmiss_install", fin_cnt - fin0, 1);

        cur_name = "clflush_clean";
        request(MO_CLFLUSH, 0);

        cur_name = "refill_then_store";
        request(MO_LOAD, 0);
        request(MO_STORE, 0);

        cur_name = "store_miss_dirty";
        req_tag = 6;
        s0 = step_cnt; pw0 = pw_cnt; fin0 = fin_cnt;
        request(MO_STORE, 0);
        check_lit("stmiss_cycles", step_cnt - s0, 18);
        check_lit("stmiss_writes", pw_cnt - pw0, 9);
        check_lit("stmiss_install", fin_cnt - fin0, 1);

        cur_name = "clflush_dirty_fast";
        request(MO_CLFLUSH, 0);

        cur_name = "reset_mid_alloc";
        req_tag = 7;
        fin0 = fin_cnt;
        begin
            outs_t e;
            pipe_req_valid = 1'b1;
            pipe_req_type  = MO_LOAD;
            e = base(); e.sna = 1'b1;
            step(1'b0, e);
            for (int w = 0; w < 3; w++) begin
                e = burst_e(1'b0, w); e.pw = 1'b1;
                step(1'b1, e);
            end
            step(1'b0, burst_e(1'b0, 3));
            reset = 1'b0;
            exp   = base();
            @(posedge clk);
            #1;
            pipe_req_valid = 1'b0;
            reset          = 1'b1;
            repeat (3) step(1'b0, base());
        end
        check_lit("reset_no_install", fin_cnt - fin0, 0);

        cur_name = "load_after_reset";
        s0 = step_cnt;
        request(MO_LOAD, 0);
        check_lit("post_reset_cycles", step_cnt - s0, 10);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
